// File: rtl/parity_lane_pkg.sv
// Shared types and arithmetic helpers for the parity lane monitor.
package parity_lane_pkg;

    localparam int DEF_NLANES = 8;
    localparam int DEF_CW     = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RPT  = 2'd2
    } state_t;

    // Callers zero-extend their vector; lanes beyond 64 are not supported.
    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += 32'(v[i]);
        end
        return n;
    endfunction

    function automatic int unsigned sat_add(input int unsigned a, input int unsigned b,
                                            input int unsigned cw);
        longint unsigned sum;
        longint unsigned max_val;
        sum     = 64'(a) + 64'(b);
        max_val = (64'd1 << cw) - 64'd1;
        return (sum > max_val) ? 32'(max_val) : 32'(sum);
    endfunction

endpackage

// File: rtl/parity_lane_popcnt.sv
// Combinational popcount of an NLANES-bit vector, clamped to a CW-bit result.
module parity_lane_popcnt
    import parity_lane_pkg::*;
#(
    parameter int NLANES = DEF_NLANES,
    parameter int CW     = DEF_CW
) (
    input  logic [NLANES-1:0] vec_i,
    output logic [CW-1:0]     cnt_o
);

    always_comb begin
        cnt_o = CW'(sat_add(popcount(64'(vec_i)), 32'd0, CW));
    end

endmodule

// File: rtl/parity_lane_monitor.sv
// Frame-based checker of the lane parity vector against expected parity.
// Optional PARITY_LANE_MON_CNT_EN adds per-lane lifetime mismatch counters (rd_lane/rd_cnt).
module parity_lane_monitor
    import parity_lane_pkg::*;
#(
    parameter  int NLANES    = DEF_NLANES,
    parameter  int FRAME_LEN = 4,
    parameter  int CW        = DEF_CW,
    localparam int FW        = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1,
    localparam int LW        = (NLANES > 1) ? $clog2(NLANES) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [NLANES-1:0] in_bits,
    input  logic [NLANES-1:0] in_exp,
    output logic              rpt_valid,
    input  logic              rpt_ready,
    output logic [NLANES-1:0] rpt_mask,
    output logic [CW-1:0]     rpt_errs,
    output logic [FW-1:0]     rpt_first,
`ifdef PARITY_LANE_MON_CNT_EN
    input  logic [LW-1:0]     rd_lane,
    output logic [CW-1:0]     rd_cnt,
`endif
    output logic              busy
);

    state_t            state_q;
    logic [FW-1:0]     idx_q;
    logic [NLANES-1:0] mask_q;
    logic [CW-1:0]     errs_q;
    logic [FW-1:0]     first_q;
    logic              seen_q;
    logic              in_ready_q;
    logic              busy_q;
    logic              rpt_valid_q;
    logic [NLANES-1:0] rpt_mask_q;
    logic [CW-1:0]     rpt_errs_q;
    logic [FW-1:0]     rpt_first_q;

    logic [NLANES-1:0] diff;
    logic [CW-1:0]     beat_errs;
    logic              accept;
    logic              last_beat;
    logic [NLANES-1:0] mask_d;
    logic [CW-1:0]     errs_d;
    logic [FW-1:0]     first_d;
    logic              seen_d;

    parity_lane_popcnt #(
        .NLANES (NLANES),
        .CW     (CW)
    ) u_popcnt (
        .vec_i (diff),
        .cnt_o (beat_errs)
    );

    always_comb begin
        diff      = in_bits ^ in_exp;
        accept    = in_valid & in_ready_q;
        last_beat = (idx_q == FW'(FRAME_LEN - 1));
        mask_d    = mask_q | diff;
        errs_d    = CW'(sat_add(32'(errs_q), 32'(beat_errs), CW));
        first_d   = ((|diff) && !seen_q) ? idx_q : first_q;
        seen_d    = seen_q | (|diff);
    end

    // Accumulators clear as the report is captured, so the frame after starts clean.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            mask_q      <= '0;
            errs_q      <= '0;
            first_q     <= '0;
            seen_q      <= 1'b0;
            in_ready_q  <= 1'b1;
            busy_q      <= 1'b0;
            rpt_valid_q <= 1'b0;
            rpt_mask_q  <= '0;
            rpt_errs_q  <= '0;
            rpt_first_q <= '0;
        end else begin
            case (state_q)
                IDLE, ACC: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (last_beat) begin
                            rpt_mask_q  <= mask_d;
                            rpt_errs_q  <= errs_d;
                            rpt_first_q <= first_d;
                            rpt_valid_q <= 1'b1;
                            in_ready_q  <= 1'b0;
                            state_q     <= RPT;
                            idx_q       <= '0;
                            mask_q      <= '0;
                            errs_q      <= '0;
                            first_q     <= '0;
                            seen_q      <= 1'b0;
                        end else begin
                            mask_q  <= mask_d;
                            errs_q  <= errs_d;
                            first_q <= first_d;
                            seen_q  <= seen_d;
                            idx_q   <= idx_q + 1'b1;
                            state_q <= ACC;
                        end
                    end
                end
                RPT: begin
                    if (rpt_valid_q && rpt_ready) begin
                        rpt_valid_q <= 1'b0;
                        rpt_mask_q  <= '0;
                        rpt_errs_q  <= '0;
                        rpt_first_q <= '0;
                        in_ready_q  <= 1'b1;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    in_ready_q <= 1'b1;
                    busy_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign busy      = busy_q;
    assign rpt_valid = rpt_valid_q;
    assign rpt_mask  = rpt_mask_q;
    assign rpt_errs  = rpt_errs_q;
    assign rpt_first = rpt_first_q;

`ifdef PARITY_LANE_MON_CNT_EN
    logic [NLANES*CW-1:0] cnt_flat;
    logic [CW-1:0]        rd_cnt_q;

    for (genvar gi = 0; gi < NLANES; gi++) begin : g_cnt
        logic [CW-1:0] cnt_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                cnt_q <= '0;
            end else if (accept && diff[gi] && (cnt_q != '1)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
        assign cnt_flat[gi*CW +: CW] = cnt_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt_q <= '0;
        end else begin
            rd_cnt_q <= cnt_flat[32'(rd_lane)*CW +: CW];
        end
    end

    assign rd_cnt = rd_cnt_q;
`endif

endmodule

// File: tb/tb_parity_lane_monitor.sv
// Scoreboard bench: a CW=8 and a CW=4 monitor share stimulus; reports are checked as they are consumed.
module tb_parity_lane_monitor;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] in_bits = 8'h00;
    logic [7:0] in_exp = 8'h00;
    logic       rpt_ready = 1'b1;

    logic       in_ready, rpt_valid, busy;
    logic [7:0] rpt_mask, rpt_errs;
    logic [1:0] rpt_first;

    logic       s_in_ready, s_rpt_valid, s_busy;
    logic [7:0] s_rpt_mask;
    logic [3:0] s_rpt_errs;
    logic [1:0] s_rpt_first;

`ifdef PARITY_LANE_MON_CNT_EN
    logic [2:0] rd_lane = 3'd0;
    logic [7:0] rd_cnt;
    logic [3:0] s_rd_cnt;
`endif

    typedef struct {
        logic [7:0] mask;
        logic [7:0] errs;
        logic [1:0] first;
    } rpt_t;

    rpt_t exp_q1[$];
    rpt_t exp_q2[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    always #5 clk = ~clk;

    parity_lane_monitor #(.NLANES(8), .FRAME_LEN(4), .CW(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_bits(in_bits), .in_exp(in_exp), .rpt_valid(rpt_valid), .rpt_ready(rpt_ready),
        .rpt_mask(rpt_mask), .rpt_errs(rpt_errs), .rpt_first(rpt_first),
`ifdef PARITY_LANE_MON_CNT_EN
        .rd_lane(rd_lane), .rd_cnt(rd_cnt),
`endif
        .busy(busy)
    );

    parity_lane_monitor #(.NLANES(8), .FRAME_LEN(4), .CW(4)) dut_sat (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready),
        .in_bits(in_bits), .in_exp(in_exp), .rpt_valid(s_rpt_valid), .rpt_ready(rpt_ready),
        .rpt_mask(s_rpt_mask), .rpt_errs(s_rpt_errs), .rpt_first(s_rpt_first),
`ifdef PARITY_LANE_MON_CNT_EN
        .rd_lane(rd_lane), .rd_cnt(s_rd_cnt),
`endif
        .busy(s_busy)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic expect_frame(input logic [7:0] m, input logic [7:0] e8,
                                input logic [7:0] e4, input logic [1:0] f);
        rpt_t r;
        r.mask = m; r.errs = e8; r.first = f;
        exp_q1.push_back(r);
        r.errs = e4;
        exp_q2.push_back(r);
    endtask

    // Called at a negedge; returns at the negedge following the accepting posedge.
    task automatic send_beat(input logic [7:0] b, input logic [7:0] e);
        int w;
        w = 0;
        in_valid = 1'b1;
        in_bits  = b;
        in_exp   = e;
        while (!in_ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        if (!in_ready) check("beat_accept_timeout", 32'(in_ready), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Monitors look just after the negedge at what the next posedge will hand over.
    initial begin
        rpt_t r;
        forever begin
            @(negedge clk);
            #1;
            if (rpt_valid && rpt_ready) begin
                if (exp_q1.size() == 0) begin
                    check("dut_unexpected_report", 32'(rpt_valid), 32'd0);
                end else begin
                    r = exp_q1.pop_front();
                    $display("report cw8: mask=%02h errs=%0d first=%0d", rpt_mask, rpt_errs, rpt_first);
                    check("cw8_rpt_mask", 32'(rpt_mask), 32'(r.mask));
                    check("cw8_rpt_errs", 32'(rpt_errs), 32'(r.errs));
                    check("cw8_rpt_first", 32'(rpt_first), 32'(r.first));
                end
            end
        end
    end

    initial begin
        rpt_t r;
        forever begin
            @(negedge clk);
            #1;
            if (s_rpt_valid && rpt_ready) begin
                if (exp_q2.size() == 0) begin
                    check("dut_sat_unexpected_report", 32'(s_rpt_valid), 32'd0);
                end else begin
                    r = exp_q2.pop_front();
                    $display("report cw4: mask=%02h errs=%0d first=%0d", s_rpt_mask, s_rpt_errs, s_rpt_first);
                    check("cw4_rpt_mask", 32'(s_rpt_mask), 32'(r.mask));
                    check("cw4_rpt_errs", 32'(s_rpt_errs), 32'(r.errs));
                    check("cw4_rpt_first", 32'(s_rpt_first), 32'(r.first));
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: time limit reached, got no end of test, expected $finish");
        $fatal(1);
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_rpt_valid", 32'(rpt_valid), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_rpt_errs", 32'(rpt_errs), 32'd0);
        check("reset_rpt_mask", 32'(rpt_mask), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", 32'(in_ready), 32'd1);

        // Clean frame, plus report latency
        expect_frame(8'h00, 8'd0, 8'd0, 2'd0);
        for (int i = 0; i < 3; i++) send_beat(8'h07, 8'h07);
        check("busy_mid_frame", 32'(busy), 32'd1);
        check("rpt_valid_early", 32'(rpt_valid), 32'd0);
        send_beat(8'h07, 8'h07);
        check("rpt_latency", 32'(rpt_valid), 32'd1);
        @(negedge clk);

        // Single mismatching beat at index 1
        expect_frame(8'h46, 8'd3, 8'd3, 2'd1);
        send_beat(8'h07, 8'h07);
        send_beat(8'h41, 8'h07);
        send_beat(8'h07, 8'h07);
        send_beat(8'h07, 8'h07);
        @(negedge clk);

        // Backpressured report with in_valid held high
        rpt_ready = 1'b0;
        expect_frame(8'h81, 8'd2, 8'd2, 2'd3);
        for (int i = 0; i < 3; i++) send_beat(8'h00, 8'h00);
        send_beat(8'h81, 8'h00);
        in_valid = 1'b1;
        in_bits  = 8'hAA;
        in_exp   = 8'h00;
        for (int i = 0; i < 5; i++) begin
            check("stall_in_ready", 32'(in_ready), 32'd0);
            check("stall_rpt_valid", 32'(rpt_valid), 32'd1);
            check("stall_rpt_mask", 32'(rpt_mask), 32'h81);
            check("stall_rpt_errs", 32'(rpt_errs), 32'd2);
            check("stall_rpt_first", 32'(rpt_first), 32'd3);
            @(negedge clk);
        end
        in_valid  = 1'b0;
        rpt_ready = 1'b1;
        @(negedge clk);
        check("after_accept_rpt_valid", 32'(rpt_valid), 32'd0);
        check("after_accept_busy", 32'(busy), 32'd0);
        check("after_accept_in_ready", 32'(in_ready), 32'd1);

        // All lanes failing: 32 errors, clamps to 15 in the CW=4 instance
        expect_frame(8'hFF, 8'd32, 8'd15, 2'd0);
        for (int i = 0; i < 4; i++) send_beat(8'hFF, 8'h00);
        check("sat_direct_errs", 32'(s_rpt_errs), 32'd15);
        @(negedge clk);

        // First mismatch index must not be overwritten by later ones
        expect_frame(8'h11, 8'd2, 8'd2, 2'd0);
        send_beat(8'h01, 8'h00);
        send_beat(8'h00, 8'h00);
        send_beat(8'h10, 8'h00);
        send_beat(8'h00, 8'h00);
        @(negedge clk);

        // Reset in the middle of a frame discards it
        send_beat(8'hFF, 8'h00);
        send_beat(8'hFF, 8'h00);
        rst = 1'b1;
        #1;
        check("midrst_rpt_valid", 32'(rpt_valid), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_sat_busy", 32'(s_busy), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        expect_frame(8'h00, 8'd0, 8'd0, 2'd0);
        for (int i = 0; i < 4; i++) send_beat(8'h3C, 8'h3C);
        @(negedge clk);

`ifdef PARITY_LANE_MON_CNT_EN
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        for (int f = 0; f < 2; f++) begin
            expect_frame(8'h01, 8'd2, 8'd2, 2'd0);
            send_beat(8'h01, 8'h00);
            send_beat(8'h01, 8'h00);
            send_beat(8'h00, 8'h00);
            send_beat(8'h00, 8'h00);
            @(negedge clk);
        end
        rd_lane = 3'd0;
        @(negedge clk);
        check("cnt_lane0", 32'(rd_cnt), 32'd4);
        check("cnt_sat_lane0", 32'(s_rd_cnt), 32'd4);
        rd_lane = 3'd1;
        @(negedge clk);
        check("cnt_lane1", 32'(rd_cnt), 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("cw8_queue_drained", 32'(exp_q1.size()), 32'd0);
        check("cw4_queue_drained", 32'(exp_q2.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
